sw_debounce_io: RTL and testbench

- Input-conditioning stage directly upstream of the MiniLab0 processor's switch input.
- Takes the raw, asynchronous SW[9:0] board switches, synchronises and debounces them, and presents a clean vector to the core.
- Also provides a small memory-mapped register window: stable value, sticky per-bit change flags, status and IRQ enable.
- A single shared debounce counter accepts a new switch vector only after it has held steady for DEBOUNCE_CYCLES.

---
 rtl/sw_io_pkg.sv | 27 ++
 rtl/sw_debounce_io_sync2.sv | 42 ++++
 rtl/sw_debounce_io.sv | 170 +++++++++++++++++
 tb/tb_sw_debounce_io.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sw_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sw_io_pkg
// Description : Shared types and constants for the switch debounce / register
//               window block: debounce FSM state encoding, register addresses
//               and read-data width.
// Revision    : 1.0 - initial release
// ============================================================================
package sw_io_pkg;

  // Debounce FSM state, explicitly one bit wide.
  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } deb_state_t;

  // Register window addresses.
  localparam logic [1:0] ADDR_STABLE = 2'd0;
  localparam logic [1:0] ADDR_CHG    = 2'd1;
  localparam logic [1:0] ADDR_STAT   = 2'd2;
  localparam logic [1:0] ADDR_IRQEN  = 2'd3;

  // Read/write data bus width.
  localparam int RD_W = 16;

endpackage : sw_io_pkg
`default_nettype wire

// File: rtl/sw_debounce_io_sync2.sv
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : Parameterised-width two-flop synchroniser for signals that are
//               asynchronous to clk.
// Ports       : clk   - destination clock
//               rst_n - asynchronous active-low reset
//               d     - asynchronous input vector
//               q     - synchronised output (second flop stage)
// Revision    : 1.0 - initial release
// ============================================================================
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_d, meta_q;
  logic [WIDTH-1:0] sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule : sync2
`default_nettype wire

// File: rtl/sw_debounce_io.sv
`default_nettype none
// ============================================================================
// Module      : sw_debounce_io
// Description : Synchronises and debounces raw board switches using a single
//               shared debounce counter, and exposes a small register window
//               (stable value, sticky W1C change flags, status, IRQ enable).
// Ports       : clk        - system clock
//               rst_n      - asynchronous active-low reset
//               sw_raw     - raw switch inputs, asynchronous to clk
//               sw_stable  - debounced switch vector
//               sw_changed - one-cycle pulse coincident with a sw_stable update
//               irq        - |(chg_flags & irq_en)
//               addr       - register select
//               rd_en      - read strobe (rd_data valid next cycle)
//               rd_data    - registered read data, holds between reads
//               wr_en      - write strobe
//               wr_data    - write data
// Revision    : 1.0 - initial release
// ============================================================================
module sw_debounce_io
  import sw_io_pkg::*;
#(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic             sw_changed,
  output logic             irq,
  input  logic [1:0]       addr,
  input  logic             rd_en,
  output logic [RD_W-1:0]  rd_data,
  input  logic             wr_en,
  input  logic [RD_W-1:0]  wr_data
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q;

  deb_state_t       state_d, state_q;
  logic [WIDTH-1:0] snap_d, snap_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [WIDTH-1:0] sw_stable_d, sw_stable_q;
  logic             sw_changed_d, sw_changed_q;
  logic [WIDTH-1:0] chg_flags_d, chg_flags_q;
  logic [WIDTH-1:0] irq_en_d, irq_en_q;
  logic [RD_W-1:0]  rd_data_d, rd_data_q;
  logic             accept;
  logic             irq_int;

  // Bits of wr_data above the switch width carry no meaning.
  if (WIDTH < RD_W) begin : g_wr_hi
    logic unused_wr_hi;
    assign unused_wr_hi = ^wr_data[RD_W-1:WIDTH];
  end

  sync2 #(
    .WIDTH (WIDTH)
  ) u_sync2 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sw_raw),
    .q     (sync_q)
  );

  // Debounce FSM: a candidate vector is captured in snap and must stay
  // unchanged for DEBOUNCE_CYCLES consecutive samples before acceptance.
  // Any difference restarts the window.
  always_comb begin
    state_d      = state_q;
    snap_d       = snap_q;
    cnt_d        = cnt_q;
    sw_stable_d  = sw_stable_q;
    sw_changed_d = 1'b0;
    accept       = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync_q != sw_stable_q) begin
          state_d = COUNT;
          snap_d  = sync_q;
          cnt_d   = '0;
        end
      end
      COUNT: begin
        if (sync_q != snap_q) begin
          snap_d = sync_q;
          cnt_d  = '0;
          // Input bounced all the way back to the accepted value.
          if (sync_q == sw_stable_q) begin
            state_d = IDLE;
          end
        end else if (cnt_q == CNT_MAX) begin
          sw_stable_d  = snap_q;
          sw_changed_d = 1'b1;
          accept       = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Register window. Clear is applied before set so a flag raised by an
  // acceptance in the same cycle as its W1C survives.
  always_comb begin
    chg_flags_d = chg_flags_q;
    irq_en_d    = irq_en_q;
    rd_data_d   = rd_data_q;

    if (wr_en && (addr == ADDR_CHG)) begin
      chg_flags_d = chg_flags_q & ~wr_data[WIDTH-1:0];
    end
    if (accept) begin
      chg_flags_d = chg_flags_d | (sw_stable_q ^ snap_q);
    end
    if (wr_en && (addr == ADDR_IRQEN)) begin
      irq_en_d = wr_data[WIDTH-1:0];
    end

    // Reads sample current register contents, so a same-cycle write to the
    // same address is not yet visible.
    if (rd_en) begin
      case (addr)
        ADDR_STABLE: rd_data_d = RD_W'(sw_stable_q);
        ADDR_CHG:    rd_data_d = RD_W'(chg_flags_q);
        ADDR_STAT:   rd_data_d = RD_W'({state_q == COUNT, irq_int});
        ADDR_IRQEN:  rd_data_d = RD_W'(irq_en_q);
        default:     rd_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      snap_q       <= '0;
      cnt_q        <= '0;
      sw_stable_q  <= '0;
      sw_changed_q <= 1'b0;
      chg_flags_q  <= '0;
      irq_en_q     <= '0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      snap_q       <= snap_d;
      cnt_q        <= cnt_d;
      sw_stable_q  <= sw_stable_d;
      sw_changed_q <= sw_changed_d;
      chg_flags_q  <= chg_flags_d;
      irq_en_q     <= irq_en_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign irq_int    = |(chg_flags_q & irq_en_q);
  assign irq        = irq_int;
  assign sw_stable  = sw_stable_q;
  assign sw_changed = sw_changed_q;
  assign rd_data    = rd_data_q;

endmodule : sw_debounce_io
`default_nettype wire

// File: tb/tb_sw_debounce_io.sv
`default_nettype none
// ============================================================================
// Module      : tb_sw_debounce_io
// Description : Directed self-checking bench for sw_debounce_io
//               (WIDTH=10, DEBOUNCE_CYCLES=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sw_debounce_io;

  logic        clk;
  logic        rst_n;
  logic [9:0]  sw_raw;
  logic [9:0]  sw_stable;
  logic        sw_changed;
  logic        irq;
  logic [1:0]  addr;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        wr_en;
  logic [15:0] wr_data;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  sw_debounce_io #(
    .WIDTH           (10),
    .DEBOUNCE_CYCLES (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_raw     (sw_raw),
    .sw_stable  (sw_stable),
    .sw_changed (sw_changed),
    .irq        (irq),
    .addr       (addr),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_data    (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    if (sw_changed === 1'b1) pulses++;
  endtask

  task automatic reg_rd(input logic [1:0] a, input logic [15:0] exp, input string tag);
    addr  = a;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk(tag, rd_data, exp);
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [15:0] d);
    addr    = a;
    wr_data = d;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    logic bad;

    rst_n   = 1'b0;
    sw_raw  = 10'h155;
    addr    = 2'd0;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 16'h0000;

    // ---------------- reset and first acceptance ----------------
    repeat (3) tick();
    chk("rst_stable", sw_stable, 16'h0000);
    chk("rst_changed", sw_changed, 16'h0000);
    chk("rst_irq", irq, 16'h0000);
    chk("rst_rddata", rd_data, 16'h0000);

    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (sw_stable !== 10'h000 || sw_changed !== 1'b0) bad = 1'b1;
    end
    chk("t1_hold_to_edge18", bad, 16'h0000);
    tick();
    chk("t1_stable_edge19", sw_stable, 16'h0155);
    chk("t1_pulse_edge19", sw_changed, 16'h0001);
    tick();
    chk("t1_pulse_drop", sw_changed, 16'h0000);
    chk("t1_pulse_count", pulses, 16'h0001);
    reg_rd(2'd1, 16'h0155, "t1_rd_chg");
    reg_rd(2'd0, 16'h0155, "t1_rd_stable");

    // ---------------- bounce on bit 0 ----------------
    sw_raw = 10'h154;
    repeat (19) tick();
    chk("t2_prep_stable", sw_stable, 16'h0154);
    pulses = 0;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sw_raw[0] = (i % 2 == 0);
      repeat (5) begin
        tick();
        if (sw_stable !== 10'h154) bad = 1'b1;
      end
    end
    sw_raw[0] = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (sw_stable !== 10'h154) bad = 1'b1;
    end
    chk("t2_no_change_while_bouncing", bad, 16'h0000);
    chk("t2_no_pulse_while_bouncing", pulses, 16'h0000);
    tick();
    chk("t2_stable_after_settle", sw_stable, 16'h0155);
    chk("t2_single_pulse", pulses, 16'h0001);

    // ---------------- short glitch fully reverted ----------------
    pulses = 0;
    sw_raw = 10'h154;
    repeat (4) tick();
    reg_rd(2'd2, 16'h0002, "t3_status_counting");
    repeat (3) tick();
    sw_raw = 10'h155;
    repeat (4) tick();
    reg_rd(2'd2, 16'h0000, "t3_status_idle");
    repeat (20) tick();
    chk("t3_stable_kept", sw_stable, 16'h0155);
    chk("t3_no_pulse", pulses, 16'h0000);
    reg_rd(2'd1, 16'h0155, "t3_chg_kept");

    // ---------------- W1C and set-vs-clear ----------------
    reg_wr(2'd1, 16'h0055);
    reg_rd(2'd1, 16'h0100, "t4_w1c");
    sw_raw = 10'h154;
    repeat (18) tick();
    addr    = 2'd1;
    wr_data = 16'h0055;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
    chk("t4_update_with_w1c", sw_changed, 16'h0001);
    chk("t4_stable", sw_stable, 16'h0154);
    reg_rd(2'd1, 16'h0101, "t4_set_wins");

    // ---------------- IRQ path and register corner cases ----------------
    reg_wr(2'd1, 16'h03FF);
    reg_wr(2'd3, 16'hFE00);
    reg_rd(2'd3, 16'h0200, "t5_irqen_upper_ignored");
    chk("t5_irq_idle", irq, 16'h0000);
    reg_wr(2'd2, 16'hFFFF);
    reg_rd(2'd2, 16'h0000, "t5_status_readonly");
    sw_raw = 10'h354;
    repeat (18) tick();
    chk("t5_irq_before_update", irq, 16'h0000);
    tick();
    chk("t5_irq_with_update", irq, 16'h0001);
    chk("t5_stable_354", sw_stable, 16'h0354);
    reg_rd(2'd2, 16'h0001, "t5_status_irq");
    reg_wr(2'd1, 16'h0200);
    chk("t5_irq_cleared", irq, 16'h0000);
    addr    = 2'd3;
    wr_data = 16'h0000;
    rd_en   = 1'b1;
    wr_en   = 1'b1;
    tick();
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    chk("t5_rd_pre_write", rd_data, 16'h0200);
    reg_rd(2'd3, 16'h0000, "t5_rd_post_write");
    reg_rd(2'd0, 16'h0354, "t5_rd_stable");

    // ---------------- asynchronous reset mid-COUNT ----------------
    pulses = 0;
    sw_raw = 10'h2FF;
    repeat (6) tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_async_stable", sw_stable, 16'h0000);
    chk("t6_async_rddata", rd_data, 16'h0000);
    chk("t6_async_changed", sw_changed, 16'h0000);
    chk("t6_async_irq", irq, 16'h0000);
    #10;
    rst_n = 1'b1;
    bad = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (sw_stable !== 10'h000) bad = 1'b1;
    end
    chk("t6_hold_to_edge18", bad, 16'h0000);
    chk("t6_no_stale_pulse", pulses, 16'h0000);
    tick();
    chk("t6_stable_edge19", sw_stable, 16'h02FF);
    chk("t6_pulse_edge19", sw_changed, 16'h0001);
    reg_rd(2'd1, 16'h02FF, "t6_chg_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_sw_debounce_io
`default_nettype wire
